// File: rtl/spike_synapse_if.sv
// Bus bundle for spike_synapse: spike input, weight write port and PSP output.
interface spike_synapse_if #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned W_SIZE = 4,
  parameter int unsigned V_SIZE = 4
);
  localparam int unsigned A_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0]          spikes;
  logic                     in_valid;
  logic                     wr_valid;
  logic                     wr_ready;
  logic [A_W-1:0]           wr_addr;
  logic signed [W_SIZE-1:0] wr_data;
  logic signed [V_SIZE-1:0] psp_out;
  logic                     out_valid;
  logic                     sat;

  // Upstream side: drives spikes and weight writes, consumes the sum.
  modport master (
    output spikes, in_valid, wr_valid, wr_addr, wr_data,
    input  wr_ready, psp_out, out_valid, sat
  );

  // Synapse side.
  modport slave (
    input  spikes, in_valid, wr_valid, wr_addr, wr_data,
    output wr_ready, psp_out, out_valid, sat
  );
endinterface

// File: rtl/spike_synapse.sv
// Presynaptic front end: masks programmable weights by the spike vector and
// produces one signed, saturated weighted sum per clock (two-stage pipeline).
module spike_synapse #(
  parameter int unsigned N_IN       = 4,
  parameter int unsigned W_SIZE     = 4,
  parameter int unsigned V_SIZE     = 4,
  parameter int          DEF_WEIGHT = 1
) (
  input logic           clk,
  input logic           rst,
  spike_synapse_if.slave bus
);

  localparam int unsigned A_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
  // Sum width: full precision of N_IN weights, widened to hold the clamp bounds.
  localparam int unsigned SUM_W = W_SIZE + $clog2(N_IN) + 1;
  localparam int unsigned X_W   = ((SUM_W > V_SIZE) ? SUM_W : V_SIZE) + 1;
  localparam logic signed [X_W-1:0] P_MAX = X_W'((2 ** (V_SIZE - 1)) - 1);
  localparam logic signed [X_W-1:0] P_MIN = ~P_MAX;

  logic signed [W_SIZE-1:0] weight [N_IN];
  logic signed [W_SIZE-1:0] masked [N_IN];
  logic                     v1;
  logic                     rdy_q;
  logic signed [V_SIZE-1:0] psp_q;
  logic                     out_valid_q;
  logic                     sat_q;

  logic                     wr_fire_c;
  logic                     addr_ok_c;
  logic signed [X_W-1:0]    sum_c;
  logic signed [V_SIZE-1:0] clamp_c;
  logic                     sat_c;

  assign wr_fire_c = bus.wr_valid && rdy_q;
  // Out-of-range addresses complete the handshake but are dropped.
  assign addr_ok_c = ({1'b0, bus.wr_addr} < (A_W + 1)'(N_IN));

  // Write port becomes ready on the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_q <= 1'b0;
    else     rdy_q <= 1'b1;
  end

  // Weight store; stage 1 below reads the pre-write value on a colliding edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) weight[i] <= W_SIZE'(DEF_WEIGHT);
    end else if (wr_fire_c && addr_ok_c) begin
      weight[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Stage 1: select each weight where its spike is present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) masked[i] <= '0;
      v1 <= 1'b0;
    end else begin
      for (int i = 0; i < N_IN; i++)
        masked[i] <= (bus.in_valid && bus.spikes[i]) ? weight[i] : '0;
      v1 <= bus.in_valid;
    end
  end

  // Full-precision sum of masked weights, then clamp to the output range.
  always_comb begin
    sum_c   = '0;
    clamp_c = '0;
    sat_c   = 1'b0;
    for (int i = 0; i < N_IN; i++) sum_c = sum_c + X_W'(masked[i]);
    if (sum_c > P_MAX) begin
      clamp_c = V_SIZE'(P_MAX);
      sat_c   = 1'b1;
    end else if (sum_c < P_MIN) begin
      clamp_c = V_SIZE'(P_MIN);
      sat_c   = 1'b1;
    end else begin
      clamp_c = V_SIZE'(sum_c);
    end
  end

  // Stage 2: register the saturated sum and its flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psp_q       <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      psp_q       <= clamp_c;
      out_valid_q <= v1;
      sat_q       <= sat_c;
    end
  end

  assign bus.wr_ready  = rdy_q;
  assign bus.psp_out   = psp_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat       = sat_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: directed cases plus random traffic
// compared against a cycle-level arithmetic model.
module tb_spike_synapse;

  localparam int N   = 4;
  localparam int DEF = 1;
  localparam int VMAX = 7;
  localparam int VMIN = -8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spike_synapse_if #(.N_IN(4), .W_SIZE(4), .V_SIZE(4)) bus ();
  spike_synapse_if #(.N_IN(3), .W_SIZE(4), .V_SIZE(4)) bus3 ();

  spike_synapse #(.N_IN(4), .W_SIZE(4), .V_SIZE(4), .DEF_WEIGHT(DEF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  spike_synapse #(.N_IN(3), .W_SIZE(4), .V_SIZE(4), .DEF_WEIGHT(DEF)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: weights, write-port readiness, the result sampled on the
  // previous edge and the result currently on the outputs.
  int m_w [N];
  bit m_rdy;
  int s1_psp, o_psp;
  bit s1_v, s1_sat, o_v, o_sat;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_w[i] = DEF;
    m_rdy = 1'b0;
    s1_psp = 0; s1_v = 1'b0; s1_sat = 1'b0;
    o_psp  = 0; o_v  = 1'b0; o_sat  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".psp"},   int'(bus.psp_out),   o_psp);
    chk({tag, ".valid"}, int'(bus.out_valid), int'(o_v));
    chk({tag, ".sat"},   int'(bus.sat),       int'(o_sat));
    chk({tag, ".ready"}, int'(bus.wr_ready),  int'(m_rdy));
  endtask

  // One clock: drive inputs, advance the model across the edge, check outputs.
  task automatic cyc(input bit v, input logic [3:0] sp,
                     input bit wv, input int wa, input int wd);
    int sum;
    bus.in_valid = v;
    bus.spikes   = sp;
    bus.wr_valid = wv;
    bus.wr_addr  = 2'(wa);
    bus.wr_data  = 4'(wd);
    @(posedge clk);
    sum = 0;
    for (int i = 0; i < N; i++) if (v && sp[i]) sum += m_w[i];
    o_psp = s1_psp; o_v = s1_v; o_sat = s1_sat;
    s1_v   = v;
    s1_sat = (sum > VMAX) || (sum < VMIN);
    s1_psp = (sum > VMAX) ? VMAX : (sum < VMIN) ? VMIN : sum;
    if (wv && m_rdy && wa < N) m_w[wa] = wd;
    m_rdy = 1'b1;
    #1;
    check_outputs("cyc");
  endtask

  task automatic wr(input int wa, input int wd);
    cyc(1'b0, 4'b0000, 1'b1, wa, wd);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.spikes = '0; bus.wr_valid = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0;
    bus3.in_valid = 1'b0; bus3.spikes = '0; bus3.wr_valid = 1'b0;
    bus3.wr_addr = '0; bus3.wr_data = '0;
    model_reset();
    #1;
    check_outputs("reset");
    release_reset();

    // Default weights; reset in mid-stream clears outputs without a clock.
    cyc(1'b1, 4'b1111, 1'b0, 0, 0);
    cyc(1'b1, 4'b1111, 1'b0, 0, 0);
    chk("default_sum", int'(bus.psp_out), 4);
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    release_reset();
    cyc(1'b1, 4'b1111, 1'b0, 0, 0);
    cyc(1'b0, 4'b0000, 1'b0, 0, 0);
    chk("post_reset_sum", int'(bus.psp_out), 4);
    chk("post_reset_valid", int'(bus.out_valid), 1);

    // Weighted sum with a negative weight.
    wr(0, 3); wr(1, 3); wr(2, 3); wr(3, -2);
    cyc(1'b1, 4'b1111, 1'b0, 0, 0);
    cyc(1'b1, 4'b1000, 1'b0, 0, 0);
    chk("sum_7", int'(bus.psp_out), 7);
    cyc(1'b0, 4'b0000, 1'b0, 0, 0);
    chk("sum_neg2", int'(bus.psp_out), -2);

    // Positive and negative saturation.
    wr(0, 5); wr(1, 5); wr(2, 0); wr(3, 0);
    cyc(1'b1, 4'b0011, 1'b0, 0, 0);
    cyc(1'b0, 4'b0000, 1'b0, 0, 0);
    chk("sat_pos", int'(bus.psp_out), 7);
    chk("sat_pos_flag", int'(bus.sat), 1);
    wr(0, -8); wr(1, -8); wr(2, -8); wr(3, -8);
    cyc(1'b1, 4'b1111, 1'b0, 0, 0);
    cyc(1'b0, 4'b0000, 1'b0, 0, 0);
    chk("sat_neg", int'(bus.psp_out), -8);
    chk("sat_neg_flag", int'(bus.sat), 1);

    // Write and sample of the same index on one edge uses the old weight.
    wr(0, 2);
    cyc(1'b1, 4'b0001, 1'b1, 0, -3);
    cyc(1'b1, 4'b0001, 1'b0, 0, 0);
    chk("collide_old", int'(bus.psp_out), 2);
    cyc(1'b0, 4'b0000, 1'b0, 0, 0);
    chk("collide_new", int'(bus.psp_out), -3);

    // Idle cycles interleaved with samples.
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    cyc(1'b1, 4'b0101, 1'b0, 0, 0);
    cyc(1'b0, 4'b0101, 1'b0, 0, 0);
    chk("idle_a", int'(bus.psp_out), 4);
    cyc(1'b1, 4'b0101, 1'b0, 0, 0);
    chk("idle_b", int'(bus.psp_out), 0);
    chk("idle_b_valid", int'(bus.out_valid), 0);
    cyc(1'b0, 4'b0000, 1'b0, 0, 0);
    chk("idle_c", int'(bus.psp_out), 4);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom % 4) != 0, 4'($urandom), ($urandom % 3) == 0,
          int'($urandom_range(0, 3)), int'($urandom_range(0, 15)) - 8);
    end

    // Three-input instance: out-of-range write is accepted and dropped.
    chk("n3_ready", int'(bus3.wr_ready), 1);
    bus3.wr_valid = 1'b1; bus3.wr_addr = 2'd3; bus3.wr_data = 4'hF;
    @(posedge clk); #1;
    bus3.wr_valid = 1'b0;
    bus3.in_valid = 1'b1; bus3.spikes = 3'b111;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0; bus3.spikes = '0;
    @(posedge clk); #1;
    chk("n3_badaddr_sum", int'(bus3.psp_out), 3);
    chk("n3_badaddr_valid", int'(bus3.out_valid), 1);
    bus3.wr_valid = 1'b1; bus3.wr_addr = 2'd2; bus3.wr_data = 4'd5;
    @(posedge clk); #1;
    bus3.wr_valid = 1'b0;
    bus3.in_valid = 1'b1; bus3.spikes = 3'b110;
    @(posedge clk); #1;
    bus3.in_valid = 1'b0; bus3.spikes = '0;
    @(posedge clk); #1;
    chk("n3_goodaddr_sum", int'(bus3.psp_out), 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
- Presynaptic front end for the LIF neuron. Converts a vector of binary spikes from upstream neurons into one signed, saturated weighted sum.
- Its output drives the neuron's signed V_SIZE-bit spike_in port directly.
- Holds one programmable signed weight per input, loaded through a valid/ready write port.
- Two-stage pipeline; one weighted sum per clock.

Parameters:
- N_IN, 4, number of presynaptic spike inputs (>= 2)
- W_SIZE, 4, signed weight width in bits
- V_SIZE, 4, signed output width; must equal the downstream neuron's V_SIZE
- DEF_WEIGHT, 1, reset value loaded into every weight register (signed, fits W_SIZE)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- spikes  input  N_IN  spike vector; bit i = spike from presynaptic neuron i
- in_valid  input  1  spikes vector is valid this cycle
- wr_valid  input  1  weight write request
- wr_ready  output  1  weight write accepted when wr_valid && wr_ready
- wr_addr  input  max(1,$clog2(N_IN))  weight index to write
- wr_data  input  W_SIZE  signed weight value
- psp_out  output  V_SIZE  signed saturated weighted sum, to the neuron's spike_in
- out_valid  output  1  psp_out holds a new sum
- sat  output  1  psp_out was clamped this sample

Behaviour:
- Reset (async, rst=1):
  - every weight = DEF_WEIGHT
  - stage-1 registers = 0
  - psp_out = 0, out_valid = 0, sat = 0, wr_ready = 0
- wr_ready: goes 1 on the first clock edge after rst deasserts and stays 1 until the next reset.
- Weight write:
  - Fires on an edge where wr_valid && wr_ready.
  - weight[wr_addr] <= wr_data.
  - If wr_addr >= N_IN, the write is accepted (handshake completes) but discarded; no weight changes.
- Stage 1, every edge:
  - masked[i] <= (in_valid && spikes[i]) ? weight[i] : 0
  - v1 <= in_valid
  - Uses weight values from before any write on the same edge. A write on edge k first affects spikes sampled on edge k+1.
- Stage 2, every edge:
  - Full-precision sum of all masked[i], sign-extended to W_SIZE+$clog2(N_IN)+1 bits. No intermediate overflow is allowed.
  - Saturate to [-2^(V_SIZE-1), 2^(V_SIZE-1)-1].
  - psp_out <= saturated value; sat <= (clamping occurred); out_valid <= v1.
- Latency: spikes sampled on edge k appear on psp_out/out_valid after edge k+1. Throughput is 1 per clock.
- When in_valid=0, zeros flow through: psp_out becomes 0, sat becomes 0, out_valid becomes 0 two edges later. The neuron therefore sees a 0 input (leak only) on idle cycles.
- No spikes asserted with in_valid=1: psp_out=0, out_valid=1.
- Simultaneous write and spike sample on the same index on the same edge: the old weight is used.
- Reset mid-pipeline discards all in-flight samples and restores default weights immediately, without waiting for a clock.
- No other state; no FSM beyond the reset-release of wr_ready.

Test Plan:
- Reset/default (N_IN=4, W=V=4, DEF_WEIGHT=1): assert rst mid-stream -> outputs 0 immediately. Release, then spikes=4'b1111, in_valid=1 -> two edges later psp_out=4, out_valid=1, sat=0.
- Weighted sum: write weights {3,3,3,-2}, spikes=4'b1111 -> psp_out=7, sat=0. Then spikes=4'b1000 -> psp_out=-2 (4'b1110).
- Saturation: weights {5,5,0,0}, spikes=4'b0011 -> psp_out=7, sat=1. Weights {-8,-8,-8,-8}, spikes=4'b1111 -> psp_out=-8, sat=1.
- Write/sample collision: weight[0]=2. On one edge, write weight[0]=-3 and sample spikes=4'b0001 -> psp_out=2. Next sample -> psp_out=-3.
- Idle/back-to-back: alternate in_valid 1,0,1 with spikes=4'b0101, weights {1,2,3,4} -> out_valid 1,0,1 and psp_out 4,0,4 on consecutive cycles.
- Bad address (N_IN=3, addr width 2): write wr_addr=3, wr_data=-1 -> handshake completes, all weights unchanged, subsequent sums unchanged.
